bz_player: RTL and testbench
============================

// Module: bz_player
// PURPOSE
//  Sequencer that reads a song from the buzzer-music block RAM and drives the buzzer pin.
//  - Drives the RAM's en/addr pins; RAM output is registered, so read latency is 1 cycle.
//  - Decodes each 12-bit word into a tone and a duration, then outputs a square wave.
//  - Sits between the control logic (start/stop/pause) and the buzzer pin.
// PARAMETERS
//  ADDR_WIDTH   11      song RAM address width; matches the RAM instance
//  DATA_WIDTH   12      song word width; fixed format below, must be 12
//  TONE_UNIT    250     clk cycles per divider LSB; half-period = div*TONE_UNIT
//  BEAT_CYCLES  5000000 clk cycles per duration LSB
// PORTS
//  clk        in   1           system clock
//  rst_n      in   1           synchronous reset, active low
//  start      in   1           1-cycle pulse; begin playback at address 0 (IDLE/DONE only)
//  stop       in   1           level; abort playback
//  pause      in   1           level; freeze playback
//  rom_en     out  1           RAM read enable (registered)
//  rom_addr   out  ADDR_WIDTH  RAM read address (registered)
//  rom_data   in   DATA_WIDTH  RAM registered read data
//  buzzer     out  1           square-wave output to the buzzer
//  busy       out  1           high in FETCH/WAIT/LOAD/PLAY
//  done       out  1           1-cycle pulse when the song ends
// BEHAVIOUR
//  Word format: [11:4] div (8b), [3:0] dur (4b).
//   - 12'h000: end of song.
//   - div==0, dur!=0: rest, buzzer low.
//   - div!=0, dur==0: zero-length note, skipped (goes straight to the next fetch).
//  Reset: every output is 0 and the FSM goes to IDLE.
//   - Reset overrides any state; it aborts mid-note with no done pulse.
//  FSM: IDLE -> FETCH -> WAIT -> LOAD -> PLAY -> FETCH ... -> DONE -> IDLE.
//  IDLE: on start (without stop), rom_addr<=0 and go to FETCH.
//  FETCH: rom_en=1 for exactly 1 cycle, with rom_addr held.
//  WAIT: rom_en=0. RAM output becomes valid in this cycle.
//  LOAD: rom_data is captured at the end of WAIT. In LOAD:
//   - end word -> DONE.
//   - otherwise load the tone counter (div*TONE_UNIT-1) and the duration counter
//     (dur*BEAT_CYCLES-1), buzzer=0, then PLAY.
//  PLAY:
//   - Tone counter decrements each cycle; at 0 it reloads and buzzer toggles
//     (rest: buzzer stays 0).
//   - Duration counter decrements; at 0: buzzer<=0, rom_addr<=rom_addr+1, go to FETCH.
//  Fetch gap is 3 cycles between notes; buzzer is held low during the gap.
//  Counter widths: size for 255*TONE_UNIT and 15*BEAT_CYCLES with no overflow.
//  Address end: after playing the word at 2**ADDR_WIDTH-1, the song ends as if an end word
//   were read (rom_addr wraps to 0).
//  DONE: done=1 for 1 cycle, then IDLE. busy=0.
//  pause=1 in PLAY:
//   - Counters freeze and buzzer is forced to 0.
//   - On release, playback resumes with the counters intact. Tone phase restarts at buzzer=0.
//   - In FETCH/WAIT/LOAD, pause takes effect once PLAY is entered.
//  stop=1 in any non-IDLE state: next cycle IDLE, buzzer=0, rom_en=0, no done pulse.
//  start and stop in the same cycle: stop wins, so the FSM stays IDLE.
//  start while busy: ignored.
// CONFIGURATION
//  BZ_PLAYER_LOOP_EN defined:
//   - The end word or the address end sets rom_addr<=0 and goes to FETCH.
//   - done pulses once per pass and busy stays 1. Only stop or reset ends playback.
//  BZ_PLAYER_LOOP_EN undefined: single pass, as described above.
// TESTING  (TONE_UNIT=2, BEAT_CYCLES=20, behavioural RAM with 1-cycle latency)
//  1. Song {051,000}, start -> rom_en at addr 0 and 1.
//     Buzzer toggles every 10 cycles for 20 cycles, then done pulses once and busy falls.
//  2. Song {003,000} (rest) -> buzzer stays 0 for 60 cycles, then done.
//  3. Song {0A2,000}, pause 15 cycles starting at PLAY cycle 7 -> buzzer 0 while paused.
//     Total note time is 40+15 cycles, then done.
//  4. stop at PLAY cycle 5, with start in the same cycle as stop -> IDLE next cycle,
//     buzzer 0, no done. A later start replays from addr 0.
//  5. Song {010,051,000}, ADDR_WIDTH=2 -> the zero-dur word is skipped. Then:
//     - LOOP_EN off: addr 0,1,2 read, done.
//     - LOOP_EN on: addr restarts at 0 and done pulses per pass.
//  6. ADDR_WIDTH=2, song {051,051,051,051} (no end word) -> after addr 3 plays:
//     - LOOP_EN off: done, rom_addr=0.
//     - LOOP_EN on: fetch from addr 0.

Source files
------------

// File: rtl/bz_player.sv
// bz_player: buzzer song sequencer reading 12-bit {div,dur} words from a 1-cycle-latency RAM; define BZ_PLAYER_LOOP_EN to repeat the song until stopped
module bz_player #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 12,
  parameter int TONE_UNIT   = 250,
  parameter int BEAT_CYCLES = 5000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  buzzer,
  output logic                  busy,
  output logic                  done
);
  localparam int TW = $clog2(255 * TONE_UNIT + 1);
  localparam int DW = $clog2(15 * BEAT_CYCLES + 1);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_PLAY, S_DONE} state_t;
  state_t state_q, state_d;
  logic rom_en_q, rom_en_d, buzzer_q, buzzer_d, done_q, done_d, next_note, fin;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [TW-1:0] tone_q, tone_d, tone_rld;
  logic [DW-1:0] dur_q, dur_d;
  assign tone_rld = TW'(word_q[11:4]) * TW'(TONE_UNIT) - TW'(1);
  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign buzzer   = buzzer_q;
  assign done     = done_q;
  assign busy     = state_q inside {S_FETCH, S_WAIT, S_LOAD, S_PLAY};
  // Next-state, address, tone/duration counters and buzzer level
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    buzzer_d   = buzzer_q;
    word_d     = word_q;
    tone_d     = tone_q;
    dur_d      = dur_q;
    done_d     = 1'b0;
    next_note  = 1'b0;
    fin        = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = start ? S_FETCH : S_IDLE;
        rom_addr_d = start ? '0 : rom_addr_q;
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        word_d  = rom_data;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (word_q == '0) fin = 1'b1;
        else if (word_q[3:0] == '0) next_note = 1'b1;
        else begin
          tone_d   = tone_rld;
          dur_d    = DW'(word_q[3:0]) * DW'(BEAT_CYCLES) - DW'(1);
          buzzer_d = 1'b0;
          state_d  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (pause) buzzer_d = 1'b0;
        else begin
          tone_d   = (tone_q == '0) ? tone_rld : tone_q - TW'(1);
          buzzer_d = (tone_q == '0 && word_q[11:4] != '0) ? !buzzer_q : buzzer_q;
          if (dur_q == '0) begin
            buzzer_d  = 1'b0;
            next_note = 1'b1;
          end else dur_d = dur_q - DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // the last address behaves like an end word once its note is over
    if (next_note) begin
      if (&rom_addr_q) fin = 1'b1;
      else begin
        rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
        state_d    = S_FETCH;
      end
    end
    if (fin) begin
      rom_addr_d = '0;
      done_d     = 1'b1;
`ifdef BZ_PLAYER_LOOP_EN
      state_d    = S_FETCH;
`else
      state_d    = S_DONE;
`endif
    end
    // stop beats everything, including a start in the same cycle
    if (stop) begin
      state_d    = S_IDLE;
      rom_addr_d = rom_addr_q;
      buzzer_d   = 1'b0;
      done_d     = 1'b0;
    end
    rom_en_d = state_d == S_FETCH;
  end
  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      buzzer_q   <= 1'b0;
      done_q     <= 1'b0;
      word_q     <= '0;
      tone_q     <= '0;
      dur_q      <= '0;
    end else begin
      state_q    <= state_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      buzzer_q   <= buzzer_d;
      done_q     <= done_d;
      word_q     <= word_d;
      tone_q     <= tone_d;
      dur_q      <= dur_d;
    end
  end
endmodule

// File: tb/tb_bz_player.sv
// tb_bz_player: bz_player checked cycle by cycle against a note-level reference model
module tb_bz_player;
  localparam int AW = 2, TU = 2, BC = 20;
  logic clk = 0, rst_n = 0, start = 0, stop = 0, pause = 0;
  logic rom_en, buzzer, busy, done;
  logic [AW-1:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] mem [4];
  int checks = 0, errors = 0, hi = 0, dc = 0;
  logic m_busy = 0, m_en = 0, m_buz = 0, m_done = 0, lv = 0, rest = 0;
  logic [AW-1:0] m_addr = 0;
  int m_gap = 0, k = 0, hh = 0, dd = 0;

  bz_player #(.ADDR_WIDTH(AW), .DATA_WIDTH(12), .TONE_UNIT(TU), .BEAT_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .buzzer(buzzer), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic end_pass();
    m_addr = 0;
    m_done = 1;
    m_gap  = 0;
`ifdef BZ_PLAYER_LOOP_EN
    m_en = 1;
`else
    m_busy = 0;
`endif
  endtask

  task automatic next_word();
    if (m_addr == AW'(3)) end_pass();
    else begin
      m_addr = m_addr + AW'(1);
      m_gap  = 0;
      m_en   = 1;
    end
  endtask

  // m_gap: 0..2 = the three fetch-gap cycles, 3 = a note is sounding
  task automatic model();
    logic [11:0] w;
    m_done = 0;
    if (!rst_n) begin
      m_busy = 0; m_en = 0; m_buz = 0; m_addr = 0; m_gap = 0;
      return;
    end
    if (stop) begin
      m_busy = 0; m_en = 0; m_buz = 0;
      return;
    end
    m_en = 0;
    if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_addr = 0; m_gap = 0; m_en = 1;
      end
      m_buz = 0;
      return;
    end
    if (m_gap < 2) m_gap++;
    else if (m_gap == 2) begin
      w = mem[m_addr];
      if (w == 0) end_pass();
      else if (w[3:0] == 0) next_word();
      else begin
        m_gap = 3; k = 0; lv = 0;
        rest = w[11:4] == 0;
        hh = int'(w[11:4]) * TU;
        dd = int'(w[3:0]) * BC;
      end
    end else if (pause) lv = 0;
    else begin
      k++;
      if (!rest) if (k % hh == 0) lv = !lv;
      if (k == dd) begin
        lv = 0;
        next_word();
      end
    end
    m_buz = (m_gap == 3) ? lv : 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    check("buzzer", buzzer, m_buz);
    check("rom_en", rom_en, m_en);
    check("rom_addr", rom_addr, m_addr);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    hi += buzzer;
    dc += done;
  endtask

  task automatic load(logic [11:0] a, logic [11:0] b, logic [11:0] c, logic [11:0] d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
    hi = 0;
    dc = 0;
  endtask

  task automatic kick();
    start = 1; step(); start = 0;
  endtask

  task automatic drain(int max);
    int n = 0;
    while (busy && n < max) begin
      step();
      n++;
    end
`ifndef BZ_PLAYER_LOOP_EN
    check("end_idle", busy, 1'b0);
`endif
    stop = 1; step(); stop = 0; step();
  endtask

  function automatic logic [11:0] rand_word();
    int t = $urandom_range(0, 5);
    logic [7:0] dv = 8'($urandom_range(1, 8));
    logic [3:0] du = 4'($urandom_range(1, 3));
    return t == 0 ? 12'h000 : t == 1 ? {8'h00, du} : t == 2 ? {dv, 4'h0} : {dv, du};
  endfunction

  initial begin
    load(0, 0, 0, 0);
    step(); step();
    rst_n = 1;
    step();
    load(12'h051, 12'h000, 0, 0);
    kick(); drain(400);
`ifndef BZ_PLAYER_LOOP_EN
    check("t1_high", hi, 10);
    check("t1_done", dc, 1);
`endif
    load(12'h003, 12'h000, 0, 0);
    kick(); drain(400);
`ifndef BZ_PLAYER_LOOP_EN
    check("t2_high", hi, 0);
    check("t2_done", dc, 1);
`endif
    load(12'h0A2, 12'h000, 0, 0);
    kick();
    repeat (10) step();
    pause = 1;
    repeat (15) step();
    pause = 0;
    drain(400);
`ifndef BZ_PLAYER_LOOP_EN
    check("t3_high", hi, 20);
    check("t3_done", dc, 1);
`endif
    load(12'h051, 12'h000, 0, 0);
    kick();
    repeat (8) step();
    stop = 1; start = 1; step(); stop = 0; start = 0;
    check("t4_busy", busy, 1'b0);
    repeat (5) step();
    check("t4_nodone", dc, 0);
    kick(); drain(400);
    load(12'h010, 12'h051, 12'h000, 12'h000);
    kick(); drain(200);
    load(12'h051, 12'h051, 12'h051, 12'h051);
    kick();
    while (busy && hi < 1000 && !done) step();
`ifndef BZ_PLAYER_LOOP_EN
    check("t6_addr", rom_addr, 0);
`endif
    drain(300);
    load(12'h051, 12'h051, 0, 0);
    kick();
    repeat (12) step();
    rst_n = 0; step(); rst_n = 1; step();
    check("rst_nodone", dc, 0);
    for (int r = 0; r < 20; r++) begin
      load(rand_word(), rand_word(), rand_word(), rand_word());
      kick();
      for (int n = 0; n < 800 && busy; n++) begin
        pause = $urandom_range(0, 7) == 0;
        start = $urandom_range(0, 15) == 0;
        step();
      end
      pause = 0; start = 0;
      drain(800);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
